// File: rtl/byte_pixel_packer.sv
// rtl/byte_pixel_packer.sv - packs a byte stream into fixed-width pixels with frame markers
module byte_pixel_packer #(
    parameter int BYTE_W          = 8,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int WIDTH           = 1280,
    parameter int HEIGHT          = 720,
    parameter int MSB_FIRST       = 1,
    parameter int IDLE_TIMEOUT    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              resync,
    input  logic [BYTE_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [BYTE_W*BYTES_PER_PIXEL-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic                              align_err
);

    localparam int N     = BYTES_PER_PIXEL;
    localparam int PIX_W = BYTE_W * N;
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int BW    = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int IW    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] LAST_BYTE  = BW'(N - 1);
    localparam logic [PW-1:0] LAST_PIX   = PW'(TOTAL - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(IDLE_TIMEOUT);

    logic [BW-1:0]    byte_cnt;
    logic [PW-1:0]    pix_cnt;
    logic [IW-1:0]    idle_cnt;
    logic [PIX_W-1:0] acc;
    logic [PIX_W-1:0] acc_next;
    logic [PIX_W-1:0] data_q;
    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic             err_q;
    logic             last_byte;
    logic             in_hs;
    logic             out_hs;
    logic             load;
    logic             timeout;
    logic [BW-1:0]    slot;

    assign last_byte = (byte_cnt == LAST_BYTE);

    // The last byte may only enter when the output register is free or draining this cycle
    assign in_ready = !(rst || resync || (last_byte && valid_q && !out_ready));
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;
    assign load     = in_hs && last_byte;

    // An accepted byte always beats an expiring idle count; resync suppresses it entirely
    assign timeout = (IDLE_TIMEOUT > 0) && (byte_cnt != '0) && (idle_cnt == IDLE_LIMIT)
                     && !in_hs && !resync;

    assign slot = (MSB_FIRST != 0) ? (LAST_BYTE - byte_cnt) : byte_cnt;

    // Accumulator with the current byte merged in, so the last byte loads straight to the output
    always_comb begin
        acc_next = acc;
        acc_next[int'(slot)*BYTE_W +: BYTE_W] = in_data;
    end

    // Outputs are forced low while reset is held, not just from the following edge
    assign out_valid = valid_q && !rst;
    assign out_sop   = sop_q && !rst;
    assign out_eop   = eop_q && !rst;
    assign align_err = err_q && !rst;
    assign out_data  = rst ? '0 : data_q;

    // Byte position within the current pixel
    always_ff @(posedge clk) begin
        if (rst || resync || timeout) begin
            byte_cnt <= '0;
        end else if (in_hs) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + BW'(1);
        end
    end

    // Pixel position within the frame; a timeout leaves it untouched
    always_ff @(posedge clk) begin
        if (rst || resync) begin
            pix_cnt <= '0;
        end else if (load) begin
            pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PW'(1);
        end
    end

    // Idle cycles spent mid-pixel, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst || resync || timeout || in_hs || byte_cnt == '0) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LIMIT) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // Partial pixel storage; stale slots are always overwritten before the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (in_hs) begin
            acc <= acc_next;
        end
    end

    // Output register: load (or replace on drain) a completed pixel, otherwise clear on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (load) begin
            data_q  <= acc_next;
            valid_q <= 1'b1;
            sop_q   <= (pix_cnt == '0);
            eop_q   <= (pix_cnt == LAST_PIX);
        end else if (out_hs) begin
            valid_q <= 1'b0;
        end
    end

    // Single-cycle flag whenever a partial pixel is thrown away
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (resync && byte_cnt != '0) || timeout;
        end
    end

endmodule

// File: tb/tb_byte_pixel_packer.sv
// tb/tb_byte_pixel_packer.sv - scoreboard and vector-table bench for byte_pixel_packer
module tb_byte_pixel_packer;

    localparam int BYTE_W = 8;
    localparam int BPP    = 3;
    localparam int W      = 4;
    localparam int H      = 2;
    localparam int MSBF   = 1;
    localparam int IDLE   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resync = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop;
    logic        out_eop;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;

    logic [25:0] exp_q[$];
    int          m_k = 0;
    int          m_pix = 0;
    logic [23:0] m_acc = '0;

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } vec_t;
    vec_t tbl[9];

    byte_pixel_packer #(
        .BYTE_W(BYTE_W), .BYTES_PER_PIXEL(BPP), .WIDTH(W), .HEIGHT(H),
        .MSB_FIRST(MSBF), .IDLE_TIMEOUT(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .resync(resync),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b, input bit push);
        int s;
        s = (MSBF != 0) ? (BPP - 1 - m_k) : m_k;
        m_acc[s*8 +: 8] = b;
        if (m_k == BPP - 1) begin
            if (push) exp_q.push_back({m_acc, m_pix == 0, m_pix == W*H - 1});
            m_pix = (m_pix + 1) % (W*H);
            m_k = 0;
        end else begin
            m_k++;
        end
    endfunction

    // Scoreboard pop on output handshakes; align_err pulses are tallied
    always @(negedge clk) begin
        if (align_err) err_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel actual=%h required=none", {out_data, out_sop, out_eop});
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                check("pixel", {6'd0, out_data, out_sop, out_eop}, {6'd0, e});
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push);
        int n;
        bit ok;
        in_data = b;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) model_byte(b, push);
        else check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        resync = 1'b0;
        in_valid = 1'b0;
        cycles(2);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_flags", {29'd0, out_sop, out_eop, align_err}, 32'd0);
        check("rst_out_data", {8'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_k = 0;
        m_pix = 0;
        err_cnt = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            cycles(1);
            n++;
        end
        cycles(2);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h11, 8'h22, 8'h33, 24'h112233, 1'b1, 1'b0};
        tbl[1] = '{8'h44, 8'h55, 8'h66, 24'h445566, 1'b0, 1'b0};
        tbl[2] = '{8'h77, 8'h88, 8'h99, 24'h778899, 1'b0, 1'b0};
        tbl[3] = '{8'hAA, 8'hBB, 8'hCC, 24'hAABBCC, 1'b0, 1'b0};
        tbl[4] = '{8'hDD, 8'hEE, 8'hFF, 24'hDDEEFF, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 8'h02, 8'h03, 24'h010203, 1'b0, 1'b0};
        tbl[6] = '{8'hA5, 8'h5A, 8'hC3, 24'hA55AC3, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'hFF, 8'h7E, 24'h00FF7E, 1'b0, 1'b1};
        tbl[8] = '{8'h12, 8'h34, 8'h56, 24'h123456, 1'b1, 1'b0};

        // Continuous frame plus one pixel of the next frame, constant expectations
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({tbl[i].data, tbl[i].sop, tbl[i].eop});
            send_byte(tbl[i].b0, 1'b0);
            send_byte(tbl[i].b1, 1'b0);
            send_byte(tbl[i].b2, 1'b0);
        end
        drain();
        check("stream_no_err", err_cnt, 32'd0);

        // Backpressure: held pixel, last byte stalls, then drain and load together
        do_reset();
        out_ready = 1'b0;
        send_pixel(8'h11, 8'h22, 8'h33);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        in_data = 8'h66;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_data", {8'd0, out_data}, 32'h00112233);
            check("hold_sop", {31'd0, out_sop}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) model_byte(8'h66, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no_bubble", {31'd0, out_valid}, 32'd1);
        drain();

        // Idle timeout mid-pixel; no timeout while aligned
        do_reset();
        out_ready = 1'b1;
        send_pixel(8'h10, 8'h20, 8'h30);
        drain();
        err_cnt = 0;
        cycles(10);
        check("idle_aligned_no_err", err_cnt, 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        cycles(10);
        check("timeout_err_once", err_cnt, 32'd1);
        m_k = 0;
        send_pixel(8'hAA, 8'hBB, 8'hCC);
        drain();

        // Resync at byte 1 with a held output pixel
        do_reset();
        out_ready = 1'b0;
        send_pixel(8'hAB, 8'hCD, 8'hEF);
        send_byte(8'h01, 1'b1);
        err_cnt = 0;
        in_data = 8'h02;
        in_valid = 1'b1;
        resync = 1'b1;
        @(negedge clk);
        check("resync_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        resync = 1'b0;
        in_valid = 1'b0;
        m_k = 0;
        m_pix = 0;
        @(negedge clk);
        check("resync_align_err", {31'd0, align_err}, 32'd1);
        check("resync_held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cycles(4);
        check("resync_err_once", err_cnt, 32'd1);
        send_pixel(8'h21, 8'h43, 8'h65);
        drain();

        // Reset mid-pixel with an output pending
        out_ready = 1'b0;
        send_pixel(8'h99, 8'h88, 8'h77);
        send_byte(8'h66, 1'b1);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_outputs", {28'd0, out_valid, out_sop, out_eop, align_err}, 32'd0);
        check("midrst_data", {8'd0, out_data}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_k = 0;
        m_pix = 0;
        out_ready = 1'b1;
        send_pixel(8'h5A, 8'h6B, 8'h7C);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_pixel_packer.md
BYTE_PIXEL_PACKER -- requirements
Module: byte_pixel_packer

Interface
REQ-001 SHALL have parameter BYTE_W, default 8: width of one input byte.
REQ-002 SHALL have parameter BYTES_PER_PIXEL, default 3, legal range 1..8: bytes packed per output pixel.
REQ-003 SHALL have parameter WIDTH, default 1280: pixels per line.
REQ-004 SHALL have parameter HEIGHT, default 720: lines per frame.
REQ-005 SHALL have parameter MSB_FIRST, default 1: 1 places the first byte in the top slice of out_data; 0 places it in the bottom slice.
REQ-006 SHALL have parameter IDLE_TIMEOUT, default 0: cycles without an input handshake before a partial pixel is dropped; 0 disables the timeout.
REQ-007 clk  input  1  sole clock; all logic is on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 resync  input  1  one-cycle request to restart byte and pixel alignment.
REQ-010 in_data  input  BYTE_W  input byte.
REQ-011 in_valid  input  1  in_data is valid.
REQ-012 in_ready  output  1  block accepts in_data this cycle.
REQ-013 out_data  output  BYTE_W*BYTES_PER_PIXEL  packed pixel.
REQ-014 out_valid  output  1  out_data, out_sop and out_eop are valid.
REQ-015 out_ready  input  1  downstream accepts the pixel.
REQ-016 out_sop  output  1  pixel is frame pixel 0.
REQ-017 out_eop  output  1  pixel is frame pixel WIDTH*HEIGHT-1.
REQ-018 align_err  output  1  one-cycle pulse when a partial pixel is discarded.

Function
REQ-019 An input handshake SHALL occur on a cycle with in_valid & in_ready; an output handshake SHALL occur on a cycle with out_valid & out_ready.
REQ-020 The byte counter SHALL count 0..BYTES_PER_PIXEL-1, advance on each input handshake, and wrap to 0 after the last byte.
REQ-021 Each accepted byte SHALL be stored in the accumulator slot given by the byte counter and MSB_FIRST; byte k of a pixel occupies bits [(N-1-k)*BYTE_W +: BYTE_W] when MSB_FIRST=1 and bits [k*BYTE_W +: BYTE_W] when MSB_FIRST=0, where N = BYTES_PER_PIXEL.
REQ-022 On the handshake of the last byte, the completed pixel, including that byte, SHALL be loaded into the output register, and out_valid SHALL assert on the following cycle (latency 1).
REQ-023 The output register SHALL hold out_data, out_sop and out_eop stable while out_valid=1 and out_ready=0.
REQ-024 in_ready SHALL be 0 exactly when (the byte counter = N-1, out_valid=1 and out_ready=0) or resync=1 or rst=1; otherwise it SHALL be 1.
REQ-025 When a pixel is loaded while the previous pixel completes its output handshake in the same cycle, the new pixel SHALL replace it with no bubble, and out_valid SHALL remain 1.
REQ-026 When neither a load nor a load-replace occurs in a cycle with an output handshake, out_valid SHALL clear.
REQ-027 The pixel counter SHALL have width $clog2(WIDTH*HEIGHT), SHALL increment on each pixel load, and SHALL wrap from WIDTH*HEIGHT-1 to 0.
REQ-028 A loaded pixel SHALL carry out_sop=1 iff the pixel counter was 0 at load and out_eop=1 iff the pixel counter was WIDTH*HEIGHT-1 at load; if WIDTH*HEIGHT=1, both SHALL be 1.
REQ-029 When resync=1, the byte counter and pixel counter SHALL clear on the next edge, any partial pixel SHALL be discarded, and no byte SHALL be accepted in that cycle.
REQ-030 resync SHALL not affect an already loaded output register, which SHALL drain normally.
REQ-031 align_err SHALL pulse for one cycle when resync=1 discards a partial pixel (byte counter not 0).
REQ-032 If IDLE_TIMEOUT>0, an idle counter SHALL reset on every input handshake and SHALL count while the byte counter is not 0.
REQ-033 If IDLE_TIMEOUT>0 and the idle counter reaches IDLE_TIMEOUT, the byte counter SHALL clear, align_err SHALL pulse for one cycle, and the pixel counter SHALL be unchanged.
REQ-034 The idle counter SHALL not count while the byte counter is 0.
REQ-035 If a timeout and an input handshake coincide, the handshake SHALL win: the byte is accepted and no timeout occurs.
REQ-036 If resync and a timeout coincide, resync SHALL take priority and align_err SHALL pulse only once.
REQ-037 When BYTES_PER_PIXEL=1, every input handshake SHALL load a pixel.

Reset
REQ-038 While rst=1, out_valid, out_sop, out_eop, align_err and in_ready SHALL be 0, and out_data SHALL be 0.
REQ-039 On reset, the byte counter, pixel counter and idle counter SHALL be 0, and any partial pixel or held output SHALL be discarded.
REQ-040 rst SHALL take priority over resync and over all handshakes.
REQ-041 The first input handshake after rst deasserts SHALL be treated as byte 0 of frame pixel 0.

Verification (BYTES_PER_PIXEL=3, WIDTH=4, HEIGHT=2, BYTE_W=8, IDLE_TIMEOUT=5)
REQ-042 Bytes 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> one cycle later out_data=0x112233 (MSB_FIRST=1) or 0x332211 (MSB_FIRST=0), out_valid=1, out_sop=1.
REQ-043 24 bytes streamed continuously, out_ready=1 -> 8 pixels; out_sop on pixel 0 only, out_eop on pixel 7 only; the 9th pixel carries out_sop=1.
REQ-044 out_ready=0 with a pixel held and 2 further bytes accepted -> in_ready=0 at byte counter=2; out_data stable; out_ready=1 -> simultaneous drain and load, no bubble, no byte lost.
REQ-045 2 bytes sent then idle 5 cycles -> align_err pulses once; next bytes 0xAA,0xBB,0xCC -> out_data=0xAABBCC, pixel index unchanged.
REQ-046 resync on the same cycle as in_valid at byte counter=1 -> byte not accepted (in_ready=0), align_err=1, next pixel carries out_sop=1; a held output pixel still drains.
REQ-047 rst asserted mid-pixel with out_valid=1 -> next cycle all outputs 0; after release, 3 bytes -> a pixel with out_sop=1.
